// File: rtl/ysyx_2022040010_muldiv_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
//   - MULDIV_OP_* : RISC-V M-extension funct3 encodings
//   - muldiv_state_e : sequencer states (MULDIV_IDLE / MULDIV_CALC / MULDIV_DONE)
//   - REG_BUS / REG_ADDR_BUS : data and register-address widths
//   - rs1_signed / rs2_signed : operand signedness per operation
// Optional feature macro used by the importing modules: YSYX_2022040010_MUL_RADIX4_EN.
package ysyx_2022040010_muldiv_ctrl_pkg;

    localparam int unsigned REG_BUS      = 64;
    localparam int unsigned REG_ADDR_BUS = 5;

    localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
    localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
    localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
    localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
    localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
    localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
    localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
    localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MULDIV_IDLE = 2'd0,
        MULDIV_CALC = 2'd1,
        MULDIV_DONE = 2'd2
    } muldiv_state_e;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic rs1_signed(input logic [2:0] op);
        return (op == MULDIV_OP_MULH) || (op == MULDIV_OP_MULHSU) ||
               (op == MULDIV_OP_DIV)  || (op == MULDIV_OP_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM only.
    function automatic logic rs2_signed(input logic [2:0] op);
        return (op == MULDIV_OP_MULH) || (op == MULDIV_OP_DIV) || (op == MULDIV_OP_REM);
    endfunction

endpackage

// File: rtl/ysyx_2022040010_muldiv_step.sv
// Combinational single-iteration datapath of the multiply/divide sequencer.
// The 2*XLEN accumulator is shared by both operations:
//   multiply: {partial product high, remaining multiplier bits}; the step adds the
//             multiplicand (or 0/1/2/3x with the radix-4 build) to the high half and
//             shifts right by one (two) bits.
//   divide:   {partial remainder, dividend/quotient}; the step shifts left by one and
//             performs a restoring trial subtraction of the divisor.
// Ports:
//   is_div   in   select divide step (1) or multiply step (0)
//   acc      in   current accumulator
//   opnd     in   multiplicand magnitude or divisor magnitude
//   opnd_x3  in   3x multiplicand (only with YSYX_2022040010_MUL_RADIX4_EN)
//   acc_next out  accumulator after one iteration
module ysyx_2022040010_muldiv_step
    import ysyx_2022040010_muldiv_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = REG_BUS
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     opnd,
`ifdef YSYX_2022040010_MUL_RADIX4_EN
    input  logic [XLEN+1:0]     opnd_x3,
`endif
    output logic [2*XLEN-1:0]   acc_next
);

    logic [XLEN:0]       trial;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   mul_next;
`ifdef YSYX_2022040010_MUL_RADIX4_EN
    logic [XLEN+1:0]     addend;
    logic [XLEN+1:0]     hi_sum;
`else
    logic [XLEN:0]       hi_sum;
`endif

    always_comb begin
        // Restoring divide: {rem, next dividend bit} minus divisor.
        trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
        if (!trial[XLEN]) begin
            div_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            div_next = {acc[2*XLEN-2:0], 1'b0};
        end

`ifdef YSYX_2022040010_MUL_RADIX4_EN
        unique case (acc[1:0])
            2'd0:    addend = '0;
            2'd1:    addend = {2'b00, opnd};
            2'd2:    addend = {1'b0, opnd, 1'b0};
            default: addend = opnd_x3;
        endcase
        // hi + 3*mcand stays below 2^(XLEN+2), so no carry is lost.
        hi_sum   = {2'b00, acc[2*XLEN-1:XLEN]} + addend;
        mul_next = {hi_sum, acc[XLEN-1:2]};
`else
        hi_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        mul_next = {hi_sum, acc[XLEN-1:1]};
`endif

        acc_next = is_div ? div_next : mul_next;
    end

endmodule

// File: rtl/ysyx_2022040010_muldiv_ctrl.sv
// Iterative multiply/divide sequencer for the RV64 execute stage.
// Accepts one M-extension op when idle, iterates a shift-add multiplier or restoring
// divider on operand magnitudes, applies the sign fix-up on the last iteration and
// presents the result under a valid/ready handshake. Stalls the pipeline while busy.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
// Macro YSYX_2022040010_MUL_RADIX4_EN: multiply retires two multiplier bits per cycle.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start_i, op_i       request and funct3 operation
//   src1_i, src2_i      rs1 / rs2 values
//   w_rd_addr_i         destination register, captured on accept
//   flush_i             abort, highest priority
//   ready_o             idle, can accept
//   stall_req_o         pipeline hold request (combinational)
//   result_valid_o      result available
//   result_ready_i      consumer takes the result
//   result_o            result value
//   w_rd_addr_o         captured destination register
module ysyx_2022040010_muldiv_ctrl
    import ysyx_2022040010_muldiv_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = REG_BUS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [2:0]              op_i,
    input  logic [XLEN-1:0]         src1_i,
    input  logic [XLEN-1:0]         src2_i,
    input  logic [REG_ADDR_BUS-1:0] w_rd_addr_i,
    input  logic                    flush_i,
    output logic                    ready_o,
    output logic                    stall_req_o,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic [XLEN-1:0]         result_o,
    output logic [REG_ADDR_BUS-1:0] w_rd_addr_o
);

    localparam int unsigned CW = $clog2(XLEN);
`ifdef YSYX_2022040010_MUL_RADIX4_EN
    localparam int unsigned MUL_N = XLEN / 2;
`else
    localparam int unsigned MUL_N = XLEN;
`endif
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0]   MUL_LAST = CW'(MUL_N - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e state_q, state_d;

    logic [CW-1:0]           cnt_q;
    logic [2*XLEN-1:0]       acc_q;
    logic [2*XLEN-1:0]       acc_next;
    logic [XLEN-1:0]         opnd_q;
    logic [2:0]              op_q;
    logic                    neg_q;
    logic [XLEN-1:0]         result_q;
    logic [REG_ADDR_BUS-1:0] rd_q;
`ifdef YSYX_2022040010_MUL_RADIX4_EN
    logic [XLEN+1:0]         opnd_x3_q;
    logic [XLEN+1:0]         x3;
`endif

    logic                    accept;
    logic                    last_iter;
    logic                    neg1, neg2;
    logic [XLEN-1:0]         abs1, abs2;
    logic                    div_zero, div_ovf, special;
    logic [XLEN-1:0]         special_res;
    logic [2*XLEN-1:0]       prod_fix;
    logic [XLEN-1:0]         div_sel, div_fix, final_res;

    // ---------------- accept-time operand conditioning ----------------
    always_comb begin
        accept = (state_q == MULDIV_IDLE) && start_i && !flush_i;

        neg1 = rs1_signed(op_i) && src1_i[XLEN-1];
        neg2 = rs2_signed(op_i) && src2_i[XLEN-1];
        // Magnitude of INT_MIN wraps to itself, which is the correct unsigned value.
        abs1 = neg1 ? ('0 - src1_i) : src1_i;
        abs2 = neg2 ? ('0 - src2_i) : src2_i;

        div_zero = op_i[2] && (src2_i == '0);
        div_ovf  = op_i[2] && !op_i[0] && (src1_i == INT_MIN) && (src2_i == '1);
        special  = div_zero || div_ovf;
        // op_i[1] distinguishes REM/REMU from DIV/DIVU.
        if (div_zero) begin
            special_res = op_i[1] ? src1_i : '1;
        end else begin
            special_res = op_i[1] ? '0 : src1_i;
        end
    end

`ifdef YSYX_2022040010_MUL_RADIX4_EN
    assign x3 = {2'b00, abs1} + {1'b0, abs1, 1'b0};
`endif

    // ---------------- iteration datapath and sign fix-up ----------------
    ysyx_2022040010_muldiv_step #(
        .XLEN     (XLEN)
    ) u_step (
        .is_div   (op_q[2]),
        .acc      (acc_q),
        .opnd     (opnd_q),
`ifdef YSYX_2022040010_MUL_RADIX4_EN
        .opnd_x3  (opnd_x3_q),
`endif
        .acc_next (acc_next)
    );

    always_comb begin
        last_iter = (cnt_q == (op_q[2] ? DIV_LAST : MUL_LAST));

        // Negating the full product also gives the right low half for MUL.
        prod_fix = neg_q ? ('0 - acc_next) : acc_next;
        div_sel  = op_q[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
        div_fix  = neg_q ? ('0 - div_sel) : div_sel;

        if (op_q[2]) begin
            final_res = div_fix;
        end else if (op_q == MULDIV_OP_MUL) begin
            final_res = prod_fix[XLEN-1:0];
        end else begin
            final_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MULDIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = MULDIV_IDLE;
        end else begin
            unique case (state_q)
                MULDIV_IDLE: if (start_i) state_d = special ? MULDIV_DONE : MULDIV_CALC;
                MULDIV_CALC: if (last_iter) state_d = MULDIV_DONE;
                MULDIV_DONE: if (result_ready_i) state_d = MULDIV_IDLE;
                default:     state_d = MULDIV_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready_o        = 1'b0;
        result_valid_o = 1'b0;
        stall_req_o    = 1'b0;
        unique case (state_q)
            MULDIV_IDLE: begin
                ready_o     = 1'b1;
                stall_req_o = start_i && !flush_i;
            end
            MULDIV_CALC: stall_req_o = 1'b1;
            MULDIV_DONE: begin
                result_valid_o = 1'b1;
                stall_req_o    = !result_ready_i;
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            result_q  <= '0;
            rd_q      <= '0;
`ifdef YSYX_2022040010_MUL_RADIX4_EN
            opnd_x3_q <= '0;
`endif
        end else if (accept) begin
            op_q   <= op_i;
            rd_q   <= w_rd_addr_i;
            cnt_q  <= '0;
            // Multiply: multiplier (rs2) in the low half, multiplicand held in opnd.
            // Divide: dividend in the low half, divisor held in opnd.
            acc_q  <= {{XLEN{1'b0}}, (op_i[2] ? abs1 : abs2)};
            opnd_q <= op_i[2] ? abs2 : abs1;
            // Remainder takes the dividend's sign; everything else sign1 ^ sign2.
            neg_q  <= (op_i[2] && op_i[1]) ? neg1 : (neg1 ^ neg2);
`ifdef YSYX_2022040010_MUL_RADIX4_EN
            opnd_x3_q <= x3;
`endif
            if (special) begin
                result_q <= special_res;
            end
        end else if ((state_q == MULDIV_CALC) && !flush_i) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + CW'(1);
            if (last_iter) begin
                result_q <= final_res;
            end
        end
    end

    assign result_o    = result_q;
    assign w_rd_addr_o = rd_q;

endmodule

// File: tb/tb_ysyx_2022040010_muldiv_ctrl.sv
// Self-checking bench for ysyx_2022040010_muldiv_ctrl: directed test-plan cases plus a
// few random operations checked against a behavioural reference model.
module tb_ysyx_2022040010_muldiv_ctrl;
    import ysyx_2022040010_muldiv_ctrl_pkg::*;

    localparam int XLEN = 64;
`ifdef YSYX_2022040010_MUL_RADIX4_EN
    localparam int MUL_LAT = XLEN / 2 + 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;
    localparam int MAX_WAIT = 200;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_i = 1'b0;
    logic [2:0]      op_i = '0;
    logic [63:0]     src1_i = '0;
    logic [63:0]     src2_i = '0;
    logic [4:0]      w_rd_addr_i = '0;
    logic            flush_i = 1'b0;
    logic            result_ready_i = 1'b1;
    logic            ready_o;
    logic            stall_req_o;
    logic            result_valid_o;
    logic [63:0]     result_o;
    logic [4:0]      w_rd_addr_o;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    ysyx_2022040010_muldiv_ctrl #(
        .XLEN           (XLEN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .op_i           (op_i),
        .src1_i         (src1_i),
        .src2_i         (src2_i),
        .w_rd_addr_i    (w_rd_addr_i),
        .flush_i        (flush_i),
        .ready_o        (ready_o),
        .stall_req_o    (stall_req_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_o       (result_o),
        .w_rd_addr_o    (w_rd_addr_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [63:0] a,
                                              input logic [63:0] b);
        logic signed [127:0] xs, xu, ys, yu, p;
        logic [63:0]         minv;
        minv = {1'b1, 63'b0};
        xs = {{64{a[63]}}, a};
        xu = {64'b0, a};
        ys = {{64{b[63]}}, b};
        yu = {64'b0, b};
        p  = '0;
        case (op)
            MULDIV_OP_MUL:    begin p = xs * ys; return p[63:0];   end
            MULDIV_OP_MULH:   begin p = xs * ys; return p[127:64]; end
            MULDIV_OP_MULHSU: begin p = xs * yu; return p[127:64]; end
            MULDIV_OP_MULHU:  begin p = xu * yu; return p[127:64]; end
            MULDIV_OP_DIV: begin
                if (b == '0) return '1;
                if (a == minv && b == '1) return a;
                return $signed(a) / $signed(b);
            end
            MULDIV_OP_DIVU: return (b == '0) ? '1 : a / b;
            MULDIV_OP_REM: begin
                if (b == '0) return a;
                if (a == minv && b == '1) return '0;
                return $signed(a) % $signed(b);
            end
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [63:0] a,
                                   input logic [63:0] b);
        logic [63:0] minv;
        minv = {1'b1, 63'b0};
        if (op[2] && (b == '0 || (!op[0] && a == minv && b == '1))) return 1;
        return op[2] ? DIV_LAT : MUL_LAT;
    endfunction

    // Called 1 time unit after a rising edge; drives the request for one cycle.
    task automatic launch(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd);
        start_i = 1'b1;
        op_i = op;
        src1_i = a;
        src2_i = b;
        w_rd_addr_i = rd;
        #3;
        check("accept_stall", stall_req_o, 1'b1);
        check("accept_ready", ready_o, 1'b1);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Push the expectation, launch, wait (bounded) for valid and check latency.
    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input logic [63:0] exp, input int lat);
        int n;
        sb.push_back('{res: exp, rd: rd});
        launch(op, a, b, rd);
        n = 1;
        while (!result_valid_o && n < MAX_WAIT) begin
            check("busy_stall", stall_req_o, 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 64'(n), 64'(lat));
    endtask

    // In the valid cycle: take the result and compare with the scoreboard head.
    task automatic retire();
        exp_t e;
        e = sb.pop_front();
        result_ready_i = 1'b1;
        #3;
        check("valid", result_valid_o, 1'b1);
        check("result", result_o, e.res);
        check("rd", 64'(w_rd_addr_o), 64'(e.rd));
        check("done_stall", stall_req_o, 1'b0);
        @(posedge clk);
        #1;
        check("ready_after", ready_o, 1'b1);
        check("valid_after", result_valid_o, 1'b0);
    endtask

    initial begin
        logic [63:0] a, b, minv;
        logic [15:0] t;
        logic [2:0]  op;
        logic        saw_valid;

        minv = {1'b1, 63'b0};

        // Reset state.
        #12;
        check("rst_ready", ready_o, 1'b1);
        check("rst_valid", result_valid_o, 1'b0);
        check("rst_stall", stall_req_o, 1'b0);
        check("rst_result", result_o, 64'd0);
        check("rst_rd", 64'(w_rd_addr_o), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Start together with flush is not accepted and does not stall.
        start_i = 1'b1;
        flush_i = 1'b1;
        op_i = MULDIV_OP_MUL;
        #3;
        check("flush_start_stall", stall_req_o, 1'b0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        check("flush_start_ready", ready_o, 1'b1);

        // Directed test-plan operations.
        run_op(MULDIV_OP_MUL, 64'd3, 64'd5, 5'd7, 64'd15, MUL_LAT);
        retire();
        run_op(MULDIV_OP_DIV, -64'sd7, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT);
        retire();
        run_op(MULDIV_OP_REM, -64'sd7, 64'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, DIV_LAT);
        retire();
        run_op(MULDIV_OP_MULHU, '1, '1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT);
        retire();
        run_op(MULDIV_OP_DIVU, 64'h1234, 64'd0, 5'd4, '1, 1);
        retire();
        run_op(MULDIV_OP_REMU, 64'h1234, 64'd0, 5'd5, 64'h1234, 1);
        retire();
        run_op(MULDIV_OP_DIV, minv, '1, 5'd6, minv, 1);
        retire();
        run_op(MULDIV_OP_REM, minv, '1, 5'd8, 64'd0, 1);
        retire();

        // Flush in cycle T+10 of a divide.
        launch(MULDIV_OP_DIV, 64'd1000, 64'd3, 5'd10);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("flush_ready", ready_o, 1'b1);
        check("flush_valid", result_valid_o, 1'b0);
        saw_valid = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (result_valid_o) saw_valid = 1'b1;
        end
        check("flush_no_valid", saw_valid, 1'b0);
        run_op(MULDIV_OP_MUL, 64'd2, 64'd2, 5'd11, 64'd4, MUL_LAT);
        retire();

        // Consumer holds off for three cycles.
        result_ready_i = 1'b0;
        run_op(MULDIV_OP_DIVU, 64'd100, 64'd7, 5'd12, 64'd14, DIV_LAT);
        repeat (3) begin
            check("hold_valid", result_valid_o, 1'b1);
            check("hold_result", result_o, 64'd14);
            check("hold_rd", 64'(w_rd_addr_o), 64'd12);
            check("hold_stall", stall_req_o, 1'b1);
            @(posedge clk);
            #1;
        end
        retire();

        // Asynchronous reset in the middle of a calculation.
        launch(MULDIV_OP_DIVU, 64'd999, 64'd5, 5'd9);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready", ready_o, 1'b1);
        check("arst_valid", result_valid_o, 1'b0);
        check("arst_stall", stall_req_o, 1'b0);
        check("arst_result", result_o, 64'd0);
        check("arst_rd", 64'(w_rd_addr_o), 64'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(MULDIV_OP_DIV, -64'sd7, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT);
        retire();

        // Random operations against the reference model.
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(0, 7));
            if (i[0]) begin
                t = 16'($urandom_range(0, 200)) - 16'd100;
                a = {{48{t[15]}}, t};
                t = 16'($urandom_range(1, 60)) - 16'd30;
                b = {{48{t[15]}}, t};
            end else begin
                a = {$urandom(), $urandom()};
                b = {$urandom(), $urandom()};
            end
            run_op(op, a, b, 5'(i + 13), ref_model(op, a, b), exp_lat(op, a, b));
            retire();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_2022040010_muldiv_ctrl.md
# ysyx_2022040010_muldiv_ctrl

Iterative multiply/divide sequencer for the execute stage of the 64-bit RV64 pipeline. It accepts one M-extension operation from decode alongside the single-cycle ALU and runs a shift-add multiplier or restoring divider over many cycles. While busy it holds the pipeline with a stall request, and it returns the result to the execute result mux under a valid/ready handshake.

## Interface
- `XLEN`, 64, operand/result width (even, ≥ 8).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  operation request; accepted when `ready_o`=1.
- `op_i`  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `src1_i`  in  XLEN  rs1 value (multiplicand / dividend).
- `src2_i`  in  XLEN  rs2 value (multiplier / divisor).
- `w_rd_addr_i`  in  5  destination register, captured on accept.
- `flush_i`  in  1  abort (branch/exception); highest priority.
- `ready_o`  out  1  state == IDLE.
- `stall_req_o`  out  1  combinational: (IDLE & start_i & ~flush_i) | CALC | (DONE & ~result_ready_i).
- `result_valid_o`  out  1  state == DONE.
- `result_ready_i`  in  1  consumer takes the result this cycle.
- `result_o`  out  XLEN  final result; stable while `result_valid_o`=1.
- `w_rd_addr_o`  out  5  captured destination register.

## Operation
- Three states: IDLE, CALC, DONE.
- **Reset:** state IDLE, counter 0, `result_o` 0, `w_rd_addr_o` 0. Outputs after reset: `ready_o`=1, `result_valid_o`=0, `stall_req_o`=0.
- **IDLE → CALC** on `start_i` & ~`flush_i`.
  - Capture op, rd, operand magnitudes and the result sign.
  - Operands are signed for MULH/DIV/REM, rs1 only for MULHSU, unsigned otherwise.
- **IDLE → DONE directly (special cases):**
  - Divide by zero: quotient all-ones; remainder = dividend.
  - Signed overflow (DIV/REM of 0x8000…0 by −1): quotient = dividend; remainder = 0.
- **CALC**
  - Multiply: shift-add into a 2·XLEN product register.
  - Divide: one restoring step per cycle; quotient and remainder in XLEN registers each.
  - Counter runs 0..N−1; on the last iteration, apply sign fix-up, write `result_o`, go to DONE.
  - MUL selects the low XLEN bits; MULH* select the high XLEN bits.
  - Quotient sign = sign1 ^ sign2; remainder sign = sign of the dividend.
- **DONE → IDLE** on `result_ready_i`; otherwise hold `result_o` and `w_rd_addr_o`.
- **flush_i** in any state: next state IDLE; no `result_valid_o`; result registers may retain stale data.
- A new `start_i` is not accepted in the same cycle that DONE retires (`ready_o`=0 in DONE).

## Timing
- Accept at edge ending cycle T.
- N = XLEN iterations for divide; for multiply, N = XLEN, or XLEN/2 with the macro.
- `result_valid_o` rises in cycle T+N+1; for special cases, in cycle T+1.
- `ready_o` returns one cycle after the handshake cycle.
- Flush asserted in cycle F → `ready_o`=1 in cycle F+1.
- `stall_req_o` has no register stage; it must be high in the accepting cycle itself.

## Configuration
- `YSYX_2022040010_MUL_RADIX4_EN` defined: multiply retires 2 multiplier bits per cycle (adds 0/1/2/3 × multiplicand; the 3× term is precomputed at accept). Multiply N = XLEN/2.
- Undefined: radix-2, multiply N = XLEN.
- Division and all results are identical either way.

## Structure
- `defines.v` holds:
  - `MULDIV_OP_*` funct3 constants;
  - state encodings `MULDIV_IDLE/CALC/DONE`;
  - `RegBus`/`RegAddrBus` widths.
- One sub-module, `ysyx_2022040010_muldiv_step`: combinational single-iteration datapath (add/shift for multiply, trial-subtract for divide), parameterised by `XLEN`. The controller owns the FSM, counter, sign handling and registers.

## Test plan
- MUL 3×5, rd=7, `result_ready_i`=1 → `result_o`=15, `w_rd_addr_o`=7, valid in cycle T+65 (T+33 with macro); `stall_req_o` high T..T+64.
- DIV −7/2 and REM −7/2 → 0xFFFF_FFFF_FFFF_FFFD and 0xFFFF_FFFF_FFFF_FFFF; MULHU 0xFFFF…F × 0xFFFF…F → 0xFFFF_FFFF_FFFF_FFFE.
- DIVU 0x1234/0 → all-ones; REMU 0x1234/0 → 0x1234; DIV 0x8000_0000_0000_0000/−1 → 0x8000_0000_0000_0000. Each valid at T+1.
- `flush_i` in cycle T+10 of a DIV → `ready_o`=1 at T+11; `result_valid_o` never rises; next MUL 2×2 → 4.
- `result_ready_i` low 3 cycles after valid → `result_o`, `w_rd_addr_o`, `result_valid_o` and `stall_req_o` held; IDLE the cycle after ready rises.
- `rst` asserted mid-CALC, asynchronously → outputs immediately at reset values; first op after release is correct.
